// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter slice.
package wb_pkg;

   localparam int WB_RD_W       = 5;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_NUM_REGS   = 32;

   // Default writeback entry: destination register plus result data.
   typedef struct packed {
      logic [WB_RD_W-1:0]       rd;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_entry_t;

   // Which source owns the regfile write port in a given cycle.
   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_PIPE = 2'd1,
      WB_LL   = 2'd2
   } wb_src_e;

   // One-hot register mask; x0 never appears in the scoreboard.
   function automatic logic [WB_NUM_REGS-1:0] rd_onehot(input logic [WB_RD_W-1:0] rd);
      logic [WB_NUM_REGS-1:0] mask;
      mask     = {WB_NUM_REGS{1'b0}};
      mask[rd] = 1'b1;
      mask[0]  = 1'b0;
      return mask;
   endfunction

endpackage

// File: rtl/wb_arbiter_chk.sv
// Protocol checker: a long-latency issue must not target a register still owed,
// unless that register's pending entry is being retired in the same cycle.
module wb_arbiter_chk (
   input logic        clk,
   input logic        rst,
   input logic        ll_issue_i,
   input logic [4:0]  ll_issue_rd_i,
   input logic [31:0] busy_i,
   input logic [31:0] clr_i
);

   a_issue_not_busy : assert property (@(posedge clk) disable iff (rst)
      (ll_issue_i && (ll_issue_rd_i != 5'd0)) |-> (!busy_i[ll_issue_rd_i] || clr_i[ll_issue_rd_i]));

endmodule

// File: rtl/wb_fifo.sv
// Small skid FIFO holding long-latency completions in arrival order.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter int  CNT_W = $clog2(DEPTH) + 1,
   parameter type entry_t = wb_entry_t
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  entry_t           wdata,
   input  logic             pop,
   output entry_t           rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign count     = count_r;
   assign rdata     = mem_r[rd_ptr_r];
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the regfile write port, merges pipeline results with
// buffered long-latency completions and tracks registers still owed by LL units.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pipe_valid_i,
   input  logic [4:0]            pipe_rd_addr_i,
   input  logic [DATA_WIDTH-1:0] pipe_data_i,
   input  logic                  ll_issue_i,
   input  logic [4:0]            ll_issue_rd_i,
   input  logic                  ll_valid_i,
   output logic                  ll_ready_o,
   input  logic [4:0]            ll_rd_addr_i,
   input  logic [DATA_WIDTH-1:0] ll_data_i,
   input  logic [4:0]            dec_rs1_i,
   input  logic [4:0]            dec_rs2_i,
   input  logic [4:0]            dec_rd_i,
   output logic                  stall_o,
   output logic                  pipe_hold_o,
   output logic [31:0]           busy_o,
   output logic                  reg_write_o,
   output logic [4:0]            rd_addr_o,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   typedef struct packed {
      logic [WB_RD_W-1:0]    rd;
      logic [DATA_WIDTH-1:0] data;
   } arb_entry_t;

   localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int               AGE_W   = $clog2(STARVE_LIMIT) + 1;
   localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(STARVE_LIMIT - 1);
   localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1'b1);

   arb_entry_t       ll_entry_s;
   arb_entry_t       fifo_head_s;
   arb_entry_t       sel_entry_s;
   wb_src_e          sel_src_s;
   logic [CNT_W-1:0] fifo_count_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             fifo_push_s;
   logic             fifo_pop_s;
   logic             ll_ready_s;
   logic [31:0]      set_vec_s;
   logic [31:0]      clr_vec_s;
   logic [31:0]      busy_r;
   logic [AGE_W-1:0] age_r;
   logic             reg_write_r;
   logic [4:0]       rd_addr_r;
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Ready depends only on occupancy, so an upstream unit never waits on pipe traffic.
   assign ll_ready_s  = (fifo_count_s != CNT_W'(FIFO_DEPTH));
   assign ll_ready_o  = ll_ready_s;
   assign fifo_push_s = ll_valid_i & ll_ready_s;
   assign fifo_pop_s  = (sel_src_s == WB_LL);

   assign ll_entry_s.rd   = ll_rd_addr_i;
   assign ll_entry_s.data = ll_data_i;

   wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .CNT_W   (CNT_W),
      .entry_t (arb_entry_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push_s),
      .wdata (ll_entry_s),
      .pop   (fifo_pop_s),
      .rdata (fifo_head_s),
      .count (fifo_count_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Source priority: pipeline first, then the oldest buffered completion.
   always_comb begin
      sel_src_s = WB_NONE;
      if (pipe_valid_i) begin
         sel_src_s = WB_PIPE;
      end else if (!fifo_empty_s) begin
         sel_src_s = WB_LL;
      end else begin
         sel_src_s = WB_NONE;
      end
   end

   // Mux the winning entry onto the write path.
   always_comb begin
      sel_entry_s = '0;
      case (sel_src_s)
         WB_PIPE: begin
            sel_entry_s.rd   = pipe_rd_addr_i;
            sel_entry_s.data = pipe_data_i;
         end
         WB_LL:   sel_entry_s = fifo_head_s;
         default: sel_entry_s = '0;
      endcase
   end

   // Scoreboard set/clear masks for this cycle.
   always_comb begin
      set_vec_s = 32'h0000_0000;
      clr_vec_s = 32'h0000_0000;
      if (ll_issue_i) begin
         set_vec_s = rd_onehot(ll_issue_rd_i);
      end else begin
         set_vec_s = 32'h0000_0000;
      end
      if (fifo_pop_s) begin
         clr_vec_s = rd_onehot(fifo_head_s.rd);
      end else begin
         clr_vec_s = 32'h0000_0000;
      end
   end

   // Busy scoreboard; a set in the same cycle as a clear of the same bit wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= 32'h0000_0000;
      end else begin
         busy_r <= (busy_r & ~clr_vec_s) | set_vec_s;
      end
   end

   // Head-of-FIFO starvation age: counts cycles lost to the pipeline, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_r <= {AGE_W{1'b0}};
      end else if (fifo_empty_s || fifo_pop_s) begin
         age_r <= {AGE_W{1'b0}};
      end else if (pipe_valid_i && (age_r < AGE_SAT)) begin
         age_r <= age_r + AGE_ONE;
      end else begin
         age_r <= age_r;
      end
   end

   // Registered regfile write port; x0 destinations never assert the enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_write_r <= 1'b0;
         rd_addr_r   <= 5'd0;
         rd_data_r   <= {DATA_WIDTH{1'b0}};
      end else if (sel_src_s != WB_NONE) begin
         reg_write_r <= (sel_entry_s.rd != 5'd0);
         rd_addr_r   <= sel_entry_s.rd;
         rd_data_r   <= sel_entry_s.data;
      end else begin
         reg_write_r <= 1'b0;
      end
   end

   // Busy bits clear on the write edge; the regfile bypass covers that same cycle.
   assign stall_o = ((dec_rs1_i != 5'd0) & busy_r[dec_rs1_i])
                  | ((dec_rs2_i != 5'd0) & busy_r[dec_rs2_i])
                  | ((dec_rd_i  != 5'd0) & busy_r[dec_rd_i])
                  | fifo_full_s;

   assign pipe_hold_o = (age_r >= AGE_SAT) & pipe_valid_i & ~fifo_empty_s;
   assign busy_o      = busy_r;
   assign reg_write_o = reg_write_r;
   assign rd_addr_o   = rd_addr_r;
   assign rd_data_o   = rd_data_r;

   wb_arbiter_chk u_chk (
      .clk           (clk),
      .rst           (rst),
      .ll_issue_i    (ll_issue_i),
      .ll_issue_rd_i (ll_issue_rd_i),
      .busy_i        (busy_r),
      .clr_i         (clr_vec_s)
   );

endmodule
